// File: rtl/multiport_register_file_pkg.sv
// Shared defaults and helpers for the multi-port register file and its
// neighbours (decode, hazard unit).
package multiport_register_file_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_READ   = 2;
    localparam int DEF_NUM_WRITE  = 2;
    localparam int DEF_CNT_WIDTH  = 2;

    // Bits needed to count how many write ports hit one register (0..num_write).
    function automatic int retire_width(input int num_write);
        return $clog2(num_write + 1);
    endfunction

endpackage

// File: rtl/multiport_register_file_if.sv
// Bus bundle of the register file: read ports, write ports, the issue-time
// claim and the debug view. The pipeline drives it as master.
interface multiport_register_file_if
    import multiport_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_READ   = DEF_NUM_READ,
    parameter int NUM_WRITE  = DEF_NUM_WRITE
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [NUM_READ*ADDR_WIDTH-1:0]  read_address;
    logic [NUM_READ*DATA_WIDTH-1:0]  read_data;
    logic [NUM_READ-1:0]             read_busy;
    logic [NUM_WRITE-1:0]            write_enable;
    logic [NUM_WRITE*ADDR_WIDTH-1:0] write_address;
    logic [NUM_WRITE*DATA_WIDTH-1:0] write_data;
    logic                            claim_valid;
    logic [ADDR_WIDTH-1:0]           claim_address;
    logic                            claim_ready;
    logic [DEPTH*DATA_WIDTH-1:0]     debug_registers;
    logic [DEPTH-1:0]                debug_busy;

    modport master (
        output read_address, write_enable, write_address, write_data,
               claim_valid, claim_address,
        input  read_data, read_busy, claim_ready, debug_registers, debug_busy
    );

    modport slave (
        input  read_address, write_enable, write_address, write_data,
               claim_valid, claim_address,
        output read_data, read_busy, claim_ready, debug_registers, debug_busy
    );

endinterface

// File: rtl/multiport_register_file_counter.sv
// Per-register pending-claim counter: +1 on an accepted claim, -1 per retiring
// write port, floored at zero. The caller only asserts claim_in when the
// counter can take it, so the result never exceeds the counter's maximum.
module regfile_pending_counter #(
    parameter int CNT_WIDTH = 2,
    parameter int RET_WIDTH = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 claim_in,
    input  logic [RET_WIDTH-1:0] retire_count,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 busy,
    output logic                 full
);
    localparam int SUM_WIDTH = ((CNT_WIDTH > RET_WIDTH) ? CNT_WIDTH : RET_WIDTH) + 1;

    logic [SUM_WIDTH-1:0] avail;
    logic [SUM_WIDTH-1:0] retire;
    logic [SUM_WIDTH-1:0] next_count;

    // Add the claim first, then remove at most everything that is outstanding.
    always_comb begin
        avail      = SUM_WIDTH'(count) + SUM_WIDTH'(claim_in);
        retire     = SUM_WIDTH'(retire_count);
        next_count = (retire >= avail) ? '0 : avail - retire;
    end

    // Counter state.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= CNT_WIDTH'(next_count);
        end
    end

    assign busy = (count != '0);
    assign full = &count;

endmodule

// File: rtl/multiport_register_file.sv
// Parametrised multi-read/multi-write register file with a per-register
// pending-write scoreboard. Reads are combinational with optional same-cycle
// write forwarding; busy flags feed the hazard unit's stall logic.
module multiport_register_file
    import multiport_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_READ   = DEF_NUM_READ,
    parameter int NUM_WRITE  = DEF_NUM_WRITE,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    multiport_register_file_if.slave  bus
);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int RET_WIDTH = retire_width(NUM_WRITE);

    logic [DATA_WIDTH-1:0] regs       [DEPTH];
    logic [CNT_WIDTH-1:0]  count      [DEPTH];
    logic [RET_WIDTH-1:0]  write_hits [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      full;
    logic [DEPTH-1:0]      claim_hit;
    logic                  claim_to_zero;
    logic                  claim_accept;

    // Count enabled write ports per destination; register 0 is hard-wired
    // when ZERO_REG is set, so its writes never retire anything.
    // NOTE: every combinational output gets a default before any condition,
    // otherwise synthesis infers a latch.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            write_hits[i] = '0;
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (bus.write_enable[w] &&
                    bus.write_address[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i)) begin
                    write_hits[i] = write_hits[i] + RET_WIDTH'(1);
                end
            end
        end
        if (ZERO_REG != 0) begin
            write_hits[0] = '0;
        end
    end

    // A full counter still accepts a claim when a write retires one this cycle.
    assign claim_to_zero   = (ZERO_REG != 0) && (bus.claim_address == '0);
    assign bus.claim_ready = claim_to_zero
                           || !full[bus.claim_address]
                           || (write_hits[bus.claim_address] != '0);
    assign claim_accept    = bus.claim_valid && bus.claim_ready && !claim_to_zero;

    // One-hot decode of the accepted claim.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            claim_hit[i] = claim_accept && (bus.claim_address == ADDR_WIDTH'(i));
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_counter
        regfile_pending_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .RET_WIDTH (RET_WIDTH)
        ) u_counter (
            .clock        (clock),
            .reset_n      (reset_n),
            .claim_in     (claim_hit[i]),
            .retire_count (write_hits[i]),
            .count        (count[i]),
            .busy         (busy[i]),
            .full         (full[i])
        );
    end

    // Register array: ports are visited in ascending order so the highest
    // enabled port to the same address lands last and wins.
    // NOTE: the array is reset explicitly because the debug view and reads
    // must show zeros after reset; this costs RAM inference, which is
    // acceptable for a flop-based register file.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (bus.write_enable[w] &&
                    !((ZERO_REG != 0) && (bus.write_address[w*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
                    regs[bus.write_address[w*ADDR_WIDTH +: ADDR_WIDTH]] <=
                        bus.write_data[w*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  pend;

        assign addr = bus.read_address[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Array data, overridden by the highest matching write this cycle;
        // busy drops early when the same-cycle writes retire every claim.
        always_comb begin
            data = regs[addr];
            pend = busy[addr];
            if ((BYPASS != 0) && reset_n) begin
                for (int w = 0; w < NUM_WRITE; w++) begin
                    if (bus.write_enable[w] &&
                        bus.write_address[w*ADDR_WIDTH +: ADDR_WIDTH] == addr) begin
                        data = bus.write_data[w*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if ((int'(write_hits[addr]) >= int'(count[addr])) && !claim_hit[addr]) begin
                    pend = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
                pend = 1'b0;
            end
        end

        assign bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
        assign bus.read_busy[p]                          = pend;
    end

    // Flattened debug view of the array.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            bus.debug_registers[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

    assign bus.debug_busy = busy;

endmodule

// File: tb/tb_multiport_register_file.sv
// Randomised scoreboard bench for multiport_register_file: a driver applies
// one cycle of stimulus at a time and queues the outputs a behavioural model
// predicts; a monitor pops and compares them mid-cycle.
module tb_multiport_register_file;
    import multiport_register_file_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 2 ** AW;
    localparam int MAXC  = 3;

    typedef struct {
        logic [NR*DW-1:0] rd;
        logic [NR-1:0]    rb;
        logic             cr;
        logic [DW-1:0]    dr [DEPTH];
        logic [DEPTH-1:0] db;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    multiport_register_file_if #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_READ (NR), .NUM_WRITE (NW)
    ) bus ();

    multiport_register_file #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_READ (NR), .NUM_WRITE (NW),
        .CNT_WIDTH  (2),  .ZERO_REG   (1),  .BYPASS   (1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Stimulus of the current cycle.
    logic [NW-1:0] s_we;
    logic [AW-1:0] s_wa [NW];
    logic [DW-1:0] s_wd [NW];
    logic [AW-1:0] s_ra [NR];
    logic          s_cv;
    logic [AW-1:0] s_ca;

    // Reference model: register contents and outstanding claims per register.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt [DEPTH];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int n_writes(input int a);
        int n = 0;
        if (a == 0) return 0;
        for (int w = 0; w < NW; w++) begin
            if (s_we[w] && int'(s_wa[w]) == a) n++;
        end
        return n;
    endfunction

    function automatic bit claim_taken();
        int a = int'(s_ca);
        return s_cv && (a != 0) && ((m_cnt[a] < MAXC) || (n_writes(a) > 0));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_cnt[i] = 0;
        end
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        int   ca = int'(s_ca);
        e.cr = (ca == 0) || (m_cnt[ca] < MAXC) || (n_writes(ca) > 0);
        for (int p = 0; p < NR; p++) begin
            int            a = int'(s_ra[p]);
            logic [DW-1:0] d = m_mem[a];
            logic          b = (m_cnt[a] != 0);
            for (int w = 0; w < NW; w++) begin
                if (s_we[w] && int'(s_wa[w]) == a) d = s_wd[w];
            end
            if ((m_cnt[a] - n_writes(a) <= 0) && !(claim_taken() && ca == a)) b = 1'b0;
            if (a == 0) begin
                d = '0;
                b = 1'b0;
            end
            e.rd[p*DW +: DW] = d;
            e.rb[p]          = b;
        end
        for (int i = 0; i < DEPTH; i++) begin
            e.dr[i] = m_mem[i];
            e.db[i] = (m_cnt[i] != 0);
        end
        return e;
    endfunction

    function automatic void model_edge();
        int nc [DEPTH];
        bit tk = claim_taken();
        for (int a = 0; a < DEPTH; a++) begin
            nc[a] = m_cnt[a] + ((tk && int'(s_ca) == a) ? 1 : 0) - n_writes(a);
            if (nc[a] < 0) nc[a] = 0;
        end
        for (int w = 0; w < NW; w++) begin
            if (s_we[w] && s_wa[w] != '0) m_mem[s_wa[w]] = s_wd[w];
        end
        for (int a = 0; a < DEPTH; a++) m_cnt[a] = nc[a];
    endfunction

    task automatic set_idle();
        s_we = '0;
        s_cv = 1'b0;
        for (int w = 0; w < NW; w++) begin
            s_wa[w] = '0;
            s_wd[w] = '0;
        end
        s_ca = '0;
    endtask

    task automatic drive_bus();
        for (int w = 0; w < NW; w++) begin
            bus.write_address[w*AW +: AW] = s_wa[w];
            bus.write_data[w*DW +: DW]    = s_wd[w];
        end
        for (int p = 0; p < NR; p++) bus.read_address[p*AW +: AW] = s_ra[p];
        bus.write_enable  = s_we;
        bus.claim_valid   = s_cv;
        bus.claim_address = s_ca;
    endtask

    // One clock cycle: drive at the falling edge, queue the predicted outputs,
    // optionally pulse reset inside the low phase, then let the rising edge
    // commit and advance the model.
    task automatic step(input bit pulse_reset);
        @(negedge clock);
        drive_bus();
        if (pulse_reset) begin
            reset_n = 1'b0;
            model_clear();
        end
        exp_q.push_back(model_outputs());
        if (pulse_reset) begin
            #4;
            reset_n = 1'b1;
        end
        @(posedge clock);
        #1;
        model_edge();
    endtask

    // Monitor: compare queued predictions while the DUT outputs are stable.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < NR; p++) begin
                    check($sformatf("read_data[%0d]", p),
                          64'(bus.read_data[p*DW +: DW]), 64'(e.rd[p*DW +: DW]));
                end
                check("read_busy", 64'(bus.read_busy), 64'(e.rb));
                check("claim_ready", 64'(bus.claim_ready), 64'(e.cr));
                for (int i = 0; i < DEPTH; i++) begin
                    check($sformatf("debug_reg[%0d]", i),
                          64'(bus.debug_registers[i*DW +: DW]), 64'(e.dr[i]));
                end
                check("debug_busy", 64'(bus.debug_busy), 64'(e.db));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_clear();
        set_idle();
        for (int p = 0; p < NR; p++) s_ra[p] = '0;
        drive_bus();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Reset state.
        s_ra[0] = 5'd5; s_ra[1] = 5'd7;
        step(0);

        // Write r5, then pulse reset between edges.
        s_we = 2'b01; s_wa[0] = 5'd5; s_wd[0] = 32'hDEADBEEF;
        step(0);
        set_idle();
        step(1);
        step(0);

        // Both ports write r7: port 1 wins, forwarded the same cycle.
        s_we = 2'b11; s_wa[0] = 5'd7; s_wa[1] = 5'd7;
        s_wd[0] = 32'h11; s_wd[1] = 32'h22;
        s_ra[0] = 5'd7; s_ra[1] = 5'd5;
        step(0);
        set_idle();
        step(0);

        // Zero register ignores writes and claims.
        s_we = 2'b01; s_wa[0] = 5'd0; s_wd[0] = 32'hFFFF_FFFF;
        s_cv = 1'b1; s_ca = 5'd0; s_ra[0] = 5'd0;
        step(0);
        set_idle();
        step(0);

        // Saturate r3, try a fourth claim, then retire with three writes.
        s_ra[0] = 5'd3; s_ra[1] = 5'd3;
        s_cv = 1'b1; s_ca = 5'd3;
        repeat (4) step(0);
        s_cv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_we = 2'b10; s_wa[1] = 5'd3; s_wd[1] = 32'hA000 + k;
            step(0);
        end
        set_idle();
        s_ca = 5'd3;
        step(0);

        // Claim + write on r9 while one claim is outstanding.
        s_ra[0] = 5'd9;
        s_cv = 1'b1; s_ca = 5'd9;
        step(0);
        s_we = 2'b01; s_wa[0] = 5'd9; s_wd[0] = 32'h9999;
        step(0);
        set_idle();
        step(0);

        // Unclaimed write to r12.
        s_ra[1] = 5'd12;
        s_we = 2'b01; s_wa[0] = 5'd12; s_wd[0] = 32'h1212_3434;
        step(0);
        set_idle();
        step(0);

        // Randomised traffic concentrated on a few registers to force
        // conflicts, saturation and bypass hits.
        for (int n = 0; n < 300; n++) begin
            bit pr = ($urandom_range(0, 59) == 0);
            if (pr) begin
                set_idle();
            end else begin
                s_we = NW'($urandom);
                for (int w = 0; w < NW; w++) begin
                    s_wa[w] = AW'($urandom_range(0, 7));
                    s_wd[w] = $urandom;
                end
                s_cv = ($urandom_range(0, 2) != 0);
                s_ca = AW'($urandom_range(0, 7));
            end
            for (int p = 0; p < NR; p++) begin
                s_ra[p] = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            end
            step(pr);
        end
        set_idle();
        step(0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
